// File: rtl/dac_frame_sequencer.sv
// dac_frame_sequencer: one serial DAC frame per accepted sample.
// Drives sclk/sync/data MSB-first, then pulses the load strobe.
module dac_frame_sequencer #(
  parameter int CLK_DIV = 2,
  parameter int LDAC_HP = 2,
  parameter int GAP_HP  = 1
) (
  input  logic        MHz50Clk,
  input  logic        resetN,
  input  logic [11:0] sampleIn,
  input  logic [3:0]  cmdIn,
  input  logic        sampleValid,
  output logic        sampleReady,
  output logic        serialClock,
  output logic        syncDAC,
  output logic        dIn,
  output logic        ldac,
  output logic        busy,
  output logic [15:0] frameCount
);

  localparam int DIVW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_SHIFT  = 3'd2;
  localparam logic [2:0] S_SYNCUP = 3'd3;
  localparam logic [2:0] S_LDAC   = 3'd4;
  localparam logic [2:0] S_GAP    = 3'd5;

  logic [2:0]      r_state;
  logic [DIVW-1:0] r_divCnt;
  logic [15:0]     r_shift;
  logic [3:0]      r_bitCnt;
  logic [15:0]     r_hpCnt;
  logic            r_sclk;
  logic            r_sync;
  logic            r_din;
  logic            r_ldac;
  logic            r_ready;
  logic            r_busy;
  logic [15:0]     r_frameCount;
  logic            w_tick;
  logic            w_accept;

  assign w_tick   = (r_divCnt == DIVW'(CLK_DIV - 1));
  assign w_accept = sampleValid && r_ready;

  // Half-period divider, parked at zero while idle.
  always_ff @(posedge MHz50Clk or negedge resetN) begin
    if (!resetN) begin
      r_divCnt <= '0;
    end else if (r_state == S_IDLE || w_tick) begin
      r_divCnt <= '0;
    end else begin
      r_divCnt <= r_divCnt + 1'b1;
    end
  end

  // Frame sequencer: every output changes only on a half-period tick.
  always_ff @(posedge MHz50Clk or negedge resetN) begin
    if (!resetN) begin
      r_state      <= S_IDLE;
      r_shift      <= '0;
      r_bitCnt     <= '0;
      r_hpCnt      <= '0;
      r_sclk       <= 1'b1;
      r_sync       <= 1'b1;
      r_din        <= 1'b0;
      r_ldac       <= 1'b1;
      r_ready      <= 1'b1;
      r_busy       <= 1'b0;
      r_frameCount <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state  <= S_LOAD;
            r_shift  <= {cmdIn, sampleIn};
            r_din    <= cmdIn[3];
            r_sync   <= 1'b0;
            r_ready  <= 1'b0;
            r_busy   <= 1'b1;
            r_bitCnt <= '0;
            r_hpCnt  <= '0;
          end
        end
        S_LOAD: begin
          if (w_tick) begin
            r_state <= S_SHIFT;
            r_sclk  <= 1'b0;
          end
        end
        S_SHIFT: begin
          if (w_tick) begin
            r_sclk <= ~r_sclk;
            if (!r_sclk) begin
              if (r_bitCnt != 4'd15) begin
                r_shift  <= {r_shift[14:0], 1'b0};
                r_din    <= r_shift[14];
                r_bitCnt <= r_bitCnt + 1'b1;
              end else begin
                r_state <= S_SYNCUP;
                r_hpCnt <= '0;
              end
            end
          end
        end
        // Last bit's high half, then one sync hold half-period.
        S_SYNCUP: begin
          if (w_tick) begin
            if (r_hpCnt == 16'd1) begin
              r_state <= S_LDAC;
              r_sync  <= 1'b1;
              r_ldac  <= 1'b0;
              r_din   <= 1'b0;
              r_hpCnt <= '0;
            end else begin
              r_hpCnt <= r_hpCnt + 1'b1;
            end
          end
        end
        S_LDAC: begin
          if (w_tick) begin
            if (r_hpCnt == 16'(LDAC_HP - 1)) begin
              r_state      <= S_GAP;
              r_ldac       <= 1'b1;
              r_frameCount <= r_frameCount + 1'b1;
              r_hpCnt      <= '0;
            end else begin
              r_hpCnt <= r_hpCnt + 1'b1;
            end
          end
        end
        S_GAP: begin
          if (w_tick) begin
            if (r_hpCnt == 16'(GAP_HP - 1)) begin
              r_state <= S_IDLE;
              r_ready <= 1'b1;
              r_busy  <= 1'b0;
              r_hpCnt <= '0;
            end else begin
              r_hpCnt <= r_hpCnt + 1'b1;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_sclk  <= 1'b1;
          r_sync  <= 1'b1;
          r_ldac  <= 1'b1;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign sampleReady = r_ready;
  assign serialClock = r_sclk;
  assign syncDAC     = r_sync;
  assign dIn         = r_din;
  assign ldac        = r_ldac;
  assign busy        = r_busy;
  assign frameCount  = r_frameCount;

endmodule

// File: tb/tb_dac_frame_sequencer.sv
// tb_dac_frame_sequencer: waveform model vs two DUT configs.
// Instance 0: CLK_DIV=2 LDAC_HP=2 GAP_HP=1; instance 1: all 1.
module tb_dac_frame_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] sample_i [2];
  logic [3:0]  cmd_i    [2];
  logic        valid_i  [2];
  logic        ready_o  [2];
  logic        sclk_o   [2];
  logic        sync_o   [2];
  logic        din_o    [2];
  logic        ldac_o   [2];
  logic        busy_o   [2];
  logic [15:0] fc_o     [2];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dac_frame_sequencer #(.CLK_DIV(2), .LDAC_HP(2), .GAP_HP(1)) u_dut0 (
    .MHz50Clk(clk), .resetN(rst_n),
    .sampleIn(sample_i[0]), .cmdIn(cmd_i[0]),
    .sampleValid(valid_i[0]), .sampleReady(ready_o[0]),
    .serialClock(sclk_o[0]), .syncDAC(sync_o[0]),
    .dIn(din_o[0]), .ldac(ldac_o[0]),
    .busy(busy_o[0]), .frameCount(fc_o[0])
  );

  dac_frame_sequencer #(.CLK_DIV(1), .LDAC_HP(1), .GAP_HP(1)) u_dut1 (
    .MHz50Clk(clk), .resetN(rst_n),
    .sampleIn(sample_i[1]), .cmdIn(cmd_i[1]),
    .sampleValid(valid_i[1]), .sampleReady(ready_o[1]),
    .serialClock(sclk_o[1]), .syncDAC(sync_o[1]),
    .dIn(din_o[1]), .ldac(ldac_o[1]),
    .busy(busy_o[1]), .frameCount(fc_o[1])
  );

  function automatic int cd_of(int i);
    return (i == 0) ? 2 : 1;
  endfunction
  function automatic int l_of(int i);
    return (i == 0) ? 2 : 1;
  endfunction
  // Frame in half-periods: LOAD 1, shift 32, sync-up 1, ldac L, gap G.
  function automatic int hp_of(int i);
    return 1 + 32 + 1 + l_of(i) + 1;
  endfunction

  // Expected {sclk, sync, din, ldac, ready, busy}, n clocks after accept.
  function automatic logic [5:0] f_exp(bit act, int n, logic [15:0] w,
                                       int cd, int l);
    int h;
    int b;
    if (!act) return 6'b110110;
    h = n / cd;
    if (h == 0) return {1'b1, 1'b0, w[15], 1'b1, 1'b0, 1'b1};
    if (h <= 33) begin
      b = h / 2;
      if (b > 15) b = 15;
      return {(h > 32) || (h % 2 == 0), 1'b0, w[15 - b], 1'b1, 1'b0, 1'b1};
    end
    if (h < 34 + l) return 6'b110001;
    return 6'b110101;
  endfunction

  bit          m_act [2];
  int          m_n   [2];
  logic [15:0] m_w   [2];
  logic [15:0] m_fc  [2];
  logic [15:0] fc_bias [2] = '{16'd0, 16'd0};

  // Frame-level model: accept when idle, frame lasts hp_of*cd clocks.
  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_act[i] <= 1'b0;
        m_n[i]   <= 0;
        m_fc[i]  <= '0;
      end else if (!m_act[i]) begin
        if (valid_i[i]) begin
          m_act[i] <= 1'b1;
          m_n[i]   <= 0;
          m_w[i]   <= {cmd_i[i], sample_i[i]};
        end
      end else begin
        m_n[i] <= m_n[i] + 1;
        if (m_n[i] + 1 == hp_of(i) * cd_of(i)) m_act[i] <= 1'b0;
        if (m_n[i] + 1 == (34 + l_of(i)) * cd_of(i))
          m_fc[i] <= m_fc[i] + 16'd1;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got %0h exp %0h", nm, got, exp);
    end
  endtask

  logic [15:0] bits   [2];
  int          falls  [2];
  int          ldl    [2];
  int          t_fall [2];
  int          t_prev [2];
  logic        p_sclk [2];
  logic        p_sync [2];
  logic        p_din  [2];

  // Per-cycle compare plus capture of bits sampled on falling sclk.
  initial begin
    logic [5:0]  got;
    logic [5:0]  exp;
    logic [15:0] efc;
    for (int i = 0; i < 2; i++) begin
      bits[i] = '0; falls[i] = 0; ldl[i] = 0;
      t_fall[i] = 0; t_prev[i] = 0;
      p_sclk[i] = 1'b1; p_sync[i] = 1'b1; p_din[i] = 1'b0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        got = {sclk_o[i], sync_o[i], din_o[i], ldac_o[i],
               ready_o[i], busy_o[i]};
        exp = f_exp(m_act[i], m_n[i], m_w[i], cd_of(i), l_of(i));
        efc = m_fc[i] + fc_bias[i];
        vectors++;
        if (got !== exp || fc_o[i] !== efc) begin
          miscompares++;
          $display("FAIL cyc%0d_i%0d got %b/%h exp %b/%h",
                   cyc, i, got, fc_o[i], exp, efc);
        end
        if (p_sync[i] && !sync_o[i]) begin
          falls[i] = 0;
          ldl[i] = 0;
          t_prev[i] = t_fall[i];
          t_fall[i] = cyc;
        end
        if (p_sclk[i] && !sclk_o[i] && !sync_o[i]) begin
          bits[i] = {bits[i][14:0], din_o[i]};
          falls[i]++;
          chk($sformatf("din_stable_i%0d", i), 32'(din_o[i]), 32'(p_din[i]));
        end
        if (!ldac_o[i] && !sync_o[i]) begin
          miscompares++;
          vectors++;
          $display("FAIL sync_ldac_overlap_i%0d got 0/0 exp not both low", i);
        end
        if (!ldac_o[i]) ldl[i]++;
        p_sclk[i] = sclk_o[i];
        p_sync[i] = sync_o[i];
        p_din[i]  = din_o[i];
      end
    end
  end

  task automatic waitn(input int n);
    repeat (n) @(negedge clk);
    #2;
  endtask

  task automatic send(input int i, input logic [3:0] c, input logic [11:0] s);
    cmd_i[i] = c;
    sample_i[i] = s;
    valid_i[i] = 1'b1;
    waitn(1);
    valid_i[i] = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit hit;
    for (int i = 0; i < 2; i++) begin
      sample_i[i] = '0; cmd_i[i] = '0; valid_i[i] = 1'b0;
    end
    waitn(3);
    chk("rst_sclk", 32'(sclk_o[0]), 32'd1);
    chk("rst_sync", 32'(sync_o[0]), 32'd1);
    chk("rst_ready", 32'(ready_o[0]), 32'd1);
    chk("rst_fc", 32'(fc_o[0]), 32'd0);
    rst_n = 1'b1;
    waitn(2);

    // Single frame 0x3/0xA5C.
    send(0, 4'h3, 12'hA5C);
    waitn(80);
    chk("f1_bits", 32'(bits[0]), 32'h3A5C);
    chk("f1_falls", 32'(falls[0]), 32'd16);
    chk("f1_ldac_clks", 32'(ldl[0]), 32'd4);
    chk("f1_fc", 32'(fc_o[0]), 32'd1);

    // Back-to-back with valid held: 0x000 then 0xFFF.
    cmd_i[0] = 4'h0; sample_i[0] = 12'h000; valid_i[0] = 1'b1;
    waitn(5);
    sample_i[0] = 12'hFFF;
    waitn(75);
    valid_i[0] = 1'b0;
    waitn(80);
    chk("b2b_period", 32'(t_fall[0] - t_prev[0]), 32'd75);
    chk("b2b_bits", 32'(bits[0]), 32'h0FFF);
    chk("b2b_fc", 32'(fc_o[0]), 32'd3);

    // Valid while busy is ignored.
    send(0, 4'h1, 12'h456);
    waitn(19);
    send(0, 4'hF, 12'h123);
    waitn(70);
    chk("busy_bits", 32'(bits[0]), 32'h1456);
    chk("busy_fc", 32'(fc_o[0]), 32'd4);

    // Reset after the 7th falling edge.
    send(0, 4'h2, 12'h7E1);
    hit = 1'b0;
    for (int k = 0; k < 100 && !hit; k++) begin
      waitn(1);
      if (falls[0] == 7) hit = 1'b1;
    end
    chk("rst7_reached", 32'(hit), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst7_sync", 32'(sync_o[0]), 32'd1);
    chk("rst7_sclk", 32'(sclk_o[0]), 32'd1);
    chk("rst7_ldac", 32'(ldac_o[0]), 32'd1);
    chk("rst7_fc", 32'(fc_o[0]), 32'd0);
    waitn(2);
    rst_n = 1'b1;
    waitn(2);
    send(0, 4'hC, 12'h9C3);
    waitn(80);
    chk("post_rst_bits", 32'(bits[0]), 32'hC9C3);
    chk("post_rst_falls", 32'(falls[0]), 32'd16);
    chk("post_rst_fc", 32'(fc_o[0]), 32'd1);

    // Wrap: preset counter to 0xFFFF, one more frame gives 0.
    force u_dut0.r_frameCount = 16'hFFFF;
    fc_bias[0] = 16'hFFFF - m_fc[0];
    #1;
    release u_dut0.r_frameCount;
    waitn(1);
    chk("wrap_pre", 32'(fc_o[0]), 32'hFFFF);
    send(0, 4'h0, 12'h555);
    waitn(80);
    chk("wrap_bits", 32'(bits[0]), 32'h0555);
    chk("wrap_fc", 32'(fc_o[0]), 32'h0000);

    // Fast config: back-to-back frames 37 clocks apart.
    cmd_i[1] = 4'h3; sample_i[1] = 12'hA5C; valid_i[1] = 1'b1;
    waitn(3);
    cmd_i[1] = 4'hB; sample_i[1] = 12'h3C0;
    waitn(37);
    valid_i[1] = 1'b0;
    waitn(40);
    chk("div1_period", 32'(t_fall[1] - t_prev[1]), 32'd37);
    chk("div1_bits", 32'(bits[1]), 32'hB3C0);
    chk("div1_falls", 32'(falls[1]), 32'd16);
    chk("div1_ldac_clks", 32'(ldl[1]), 32'd1);
    chk("div1_fc", 32'(fc_o[1]), 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
